sobolrng_seq: RTL and testbench

//  Sequencer that drives the Sobol RNG core's step interface (iOneHot/iEn/iClr).
//  Per run: clears the core, then advances one sample per consumer handshake.

---
 rtl/sobolrng_seq_pkg.sv | 9 +
 rtl/sobolrng_lsz.sv | 9 +
 rtl/sobolrng_seq.sv | 72 +++++++
 tb/tb_sobolrng_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sobolrng_seq_pkg.sv
// sobolrng_seq_pkg: shared width default and sequencer state encodings for the Sobol RNG sequencer.
package sobolrng_seq_pkg;
    localparam int SOBOL_BITWIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } SeqState;
endpackage

// File: rtl/sobolrng_lsz.sv
// sobolrng_lsz: one-hot of the least-significant zero bit of iX (~x & (x+1)).
module sobolrng_lsz #(
    parameter int W = 8
) (
    input  logic [W-1:0] iX,
    output logic [W-1:0] oOneHot
);
    assign oOneHot = ~iX & (iX + 1'b1);
endmodule

// File: rtl/sobolrng_seq.sv
// sobolrng_seq: drives a Sobol RNG core's clear/step interface, one sample per consumer handshake.
// Define SOBOLSEQ_REPEAT_EN to add iRepeat, which restarts the run (via one CLR bubble) instead of idling.
module sobolrng_seq
    import sobolrng_seq_pkg::*;
#(
    parameter int BITWIDTH = SOBOL_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic [BITWIDTH:0]   iLen,
    input  logic                iStall,
    input  logic                iAbort,
`ifdef SOBOLSEQ_REPEAT_EN
    input  logic                iRepeat,
`endif
    output logic                oClr,
    output logic                oEn,
    output logic [BITWIDTH-1:0] oOneHot,
    output logic                oValid,
    output logic [BITWIDTH-1:0] oIdx,
    output logic                oBusy,
    output logic                oDone
);
    SeqState             state, stateNxt;
    logic [BITWIDTH-1:0] cnt, lsz;
    logic [BITWIDTH:0]   len;
    logic                run, consume, last, repeatRun;

    sobolrng_lsz #(.W(BITWIDTH)) uLsz (.iX(cnt), .oOneHot(lsz));

`ifdef SOBOLSEQ_REPEAT_EN
    assign repeatRun = iRepeat;
`else
    assign repeatRun = 1'b0;
`endif

    always_comb begin
        run      = (state == RUN) && !iAbort;
        consume  = run && !iStall;
        last     = {1'b0, cnt} == len - 1'b1;
        stateNxt = iAbort           ? IDLE :
                   state == IDLE    ? (iStart ? CLR : IDLE) :
                   state == CLR     ? RUN :
                   state == RUN     ? ((consume && last) ? (repeatRun ? CLR : IDLE) : RUN) :
                                      IDLE;
        oClr     = state == CLR;
        oValid   = run;
        oEn      = consume && !last;
        oDone    = consume && last;
        oOneHot  = (state == RUN) ? lsz : '0;
        oIdx     = cnt;
        oBusy    = state != IDLE;
    end

    // len==0 requests a full 2^BITWIDTH period
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= stateNxt;
            if (state == IDLE && iStart && !iAbort)
                len <= (iLen == '0) ? {1'b1, {BITWIDTH{1'b0}}} : iLen;
            if (state == CLR)
                cnt <= '0;
            else if (oEn)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sobolrng_seq.sv
// tb_sobolrng_seq: randomized scoreboard bench; a behavioural core model supplies oRand,
// expected samples come from the Gray-code form of the Sobol sequence.
module tb_sobolrng_seq;
    localparam int BW = 4;

    logic          iClk = 1'b0, iRstN = 1'b0, iStart = 1'b0, iStall = 1'b0, iAbort = 1'b0;
    logic [BW:0]   iLen = '0;
`ifdef SOBOLSEQ_REPEAT_EN
    logic          iRepeat = 1'b0;
`endif
    logic          oClr, oEn, oValid, oBusy, oDone;
    logic [BW-1:0] oOneHot, oIdx, coreRand;

    typedef struct {int idx; int val; bit last;} ExpT;
    ExpT q[$];
    int  total = 0, bad = 0;

    sobolrng_seq #(.BITWIDTH(BW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iLen(iLen), .iStall(iStall), .iAbort(iAbort),
`ifdef SOBOLSEQ_REPEAT_EN
        .iRepeat(iRepeat),
`endif
        .oClr(oClr), .oEn(oEn), .oOneHot(oOneHot), .oValid(oValid), .oIdx(oIdx),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    function automatic logic [BW-1:0] rev(input logic [BW-1:0] x);
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++) r[i] = x[BW-1-i];
        return r;
    endfunction

    // sample k = XOR of direction vectors selected by the Gray code of k
    function automatic int sob(input int k);
        logic [BW-1:0] g;
        g = BW'(k ^ (k >> 1));
        return int'(rev(g));
    endfunction

    function automatic int lowZero(input int x);
        int n = 0;
        while (((x >> n) & 1) == 1) n++;
        return 1 << n;
    endfunction

    // core model: v_i = 1 << (BW-1-i)
    always @(posedge iClk or negedge iRstN)
        if (!iRstN) coreRand <= '0;
        else if (oClr) coreRand <= '0;
        else if (oEn) coreRand <= coreRand ^ rev(oOneHot);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iClk) begin : monitor
        ExpT e;
        if (iRstN) begin
            if (oEn) begin
                chk("enGuard", {31'd0, oOneHot == '0 || oIdx == '1}, 32'd0);
                chk("onehot", 32'(oOneHot), 32'(lowZero(int'(oIdx))));
            end
            if (iAbort) begin
                chk("abortOut", {29'd0, oValid, oEn, oDone}, 32'd0);
                q.delete();
            end else if (oValid) begin
                if (q.size() == 0) chk("spurious", 32'(oIdx), 32'hFFFF_FFFF);
                else begin
                    e = q[0];
                    chk("idx", 32'(oIdx), 32'(e.idx));
                    chk("rand", 32'(coreRand), 32'(e.val));
                    if (iStall) chk("stall", {30'd0, oEn, oDone}, 32'd0);
                    else begin
                        chk("hand", {30'd0, oEn, oDone}, {30'd0, !e.last, e.last});
                        void'(q.pop_front());
                    end
                end
            end else chk("idle", {30'd0, oEn, oDone}, 32'd0);
        end
    end

    task automatic runSeq(input int len, input int stallPct, input int stallAt, input int abortAt,
                          input int periods);
        int  n = (len == 0) ? (1 << BW) : len;
        int  cyc = 0, stalls = 0, dones = 0;
        bit  aborted = 0;
        for (int p = 0; p < periods; p++)
            for (int k = 0; k < n; k++) q.push_back('{k, sob(k), k == n - 1});
        @(posedge iClk); #1;
        iLen = (BW + 1)'(len); iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        chk("clr", {29'd0, oClr, oValid, oBusy}, 32'd5);
        while (oBusy && cyc < 500) begin
            if (cyc == 1) chk("lat", {31'd0, oValid}, 32'd1);
            if (stallAt >= 0 && oValid && int'(oIdx) == stallAt && stalls < 3) begin
                iStall = 1'b1; stalls++;
            end else iStall = $urandom_range(99) < stallPct;
            iAbort = abortAt >= 0 && oValid && int'(oIdx) == abortAt;
            iStart = $urandom_range(3) == 0;
`ifdef SOBOLSEQ_REPEAT_EN
            iRepeat = dones < periods - 1;
`endif
            #1;
            if (oDone) dones++;
            @(posedge iClk); #1;
            cyc++;
            if (iAbort) begin
                aborted = 1;
                iAbort = 1'b0;
                chk("abortIdle", {31'd0, oBusy}, 32'd0);
            end
        end
        iStall = 1'b0; iStart = 1'b0; iAbort = 1'b0;
`ifdef SOBOLSEQ_REPEAT_EN
        iRepeat = 1'b0;
`endif
        chk("idleEnd", {31'd0, oBusy}, 32'd0);
        if (!aborted) begin
            chk("doneCnt", 32'(dones), 32'(periods));
            chk("drain", 32'(q.size()), 32'd0);
        end
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("reset", {oClr, oEn, oOneHot, oValid, oIdx, oBusy, oDone}, '0);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        runSeq(8, 0, -1, -1, 1);
        runSeq(0, 0, -1, -1, 1);
        runSeq(8, 0, 2, -1, 1);
        runSeq(8, 0, -1, 5, 1);
        runSeq(8, 0, -1, -1, 1);
        runSeq(1, 0, -1, -1, 1);
        runSeq(16, 30, -1, -1, 1);
        for (int r = 0; r < 24; r++)
            runSeq(int'($urandom_range(16)), int'($urandom_range(50)), -1,
                   ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1, 1);
`ifdef SOBOLSEQ_REPEAT_EN
        runSeq(4, 0, -1, -1, 3);
        runSeq(5, 25, -1, -1, 2);
`endif
        repeat (2) @(posedge iClk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
